sram_arbiter: RTL

- Two-port controller that shares the single external 256K×8 SRAM between the Atom CPU (port A) and a DMA/loader engine (port B).
- Arbitrates between the ports and generates all SRAM strobes: CS, OE and a timed WE pulse with setup and hold cycles.
- Returns read data plus a one-cycle acknowledge to the winning requester.
- Sits between the requesters and the ext_RAM* pins, replacing the direct CPU-to-SRAM path.

---
 rtl/sram_arb_pkg.sv | 30 +++
 rtl/sram_rr_pick.sv | 32 +++
 rtl/sram_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
//
// Shared definitions for the two-port external SRAM arbiter:
//   - state_t    : controller FSM states
//   - PORT_A/B   : owner / grant identifiers (A = Atom CPU, B = DMA/loader)
//   - ADDR_W_DEF : default SRAM address width (256K x 8 device)
//   - max_int    : helper used to size the shared wait counter
// ---------------------------------------------------------------------------
package sram_arb_pkg;

    localparam int ADDR_W_DEF = 18;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    function automatic int max_int(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/sram_rr_pick.sv
// ---------------------------------------------------------------------------
// sram_rr_pick
//
// Two-way round-robin picker, purely combinational.
//   a_req, b_req : pending requests
//   last_grant   : port that won the previous arbitration
//   grant_valid  : at least one request is pending
//   grant_id     : winning port (PORT_A / PORT_B)
// A lone requester always wins; on contention the port that did not win
// last time is chosen.
// ---------------------------------------------------------------------------
module sram_rr_pick
    import sram_arb_pkg::*;
(
    input  logic a_req,
    input  logic b_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = a_req | b_req;
        grant_id    = PORT_A;
        if (a_req && b_req) begin
            grant_id = ~last_grant;
        end else if (b_req) begin
            grant_id = PORT_B;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Shares one asynchronous 256K x 8 SRAM between port A (Atom CPU) and
// port B (DMA/loader). Every output is a register.
//
// Ports:
//   clk, reset            : system clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata -> a_ack/a_rdata : port A request / response
//   b_req/b_we/b_addr/b_wdata -> b_ack/b_rdata : port B request / response
//   ext_RAMCS_b/OE_b/WE_b : active-low SRAM strobes
//   ext_RAMA/ext_RAMDout  : SRAM address / write data
//   ext_RAMDin            : SRAM read data
//   busy                  : high whenever the controller is not IDLE
//
// Handshake: a requester raises req with addr/we/wdata stable and holds them
// until it samples ack=1 (a one-cycle pulse); it may drop req or present the
// next request on the following cycle. The non-owner's req is ignored until
// the controller returns to IDLE.
//
// Sequences (G = IDLE grant cycle):
//   read : RD x RD_CYCLES (CS/OE low), DONE -> ack at G+RD_CYCLES+1
//   write: WR_SETUP, WR_PULSE x WE_CYCLES (WE low), WR_HOLD, DONE
//          -> ack at G+WE_CYCLES+3
// ---------------------------------------------------------------------------
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int RD_CYCLES = 2,
    parameter int WE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [7:0]        a_wdata,
    output logic              a_ack,
    output logic [7:0]        a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_wdata,
    output logic              b_ack,
    output logic [7:0]        b_rdata,

    output logic              ext_RAMCS_b,
    output logic              ext_RAMOE_b,
    output logic              ext_RAMWE_b,
    output logic [ADDR_W-1:0] ext_RAMA,
    output logic [7:0]        ext_RAMDout,
    input  logic [7:0]        ext_RAMDin,

    output logic              busy
);

    localparam int CNT_W = $clog2(max_int(RD_CYCLES, WE_CYCLES)) + 1;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               last_grant;
    logic               owner;

    logic               grant_valid;
    logic               grant_id;
    logic               grant_take;

    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [7:0]         sel_wdata;

    sram_rr_pick u_pick (
        .a_req       (a_req),
        .b_req       (b_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Request fields of whichever port the picker selected.
    always_comb begin
        sel_we    = a_we;
        sel_addr  = a_addr;
        sel_wdata = a_wdata;
        if (grant_id == PORT_B) begin
            sel_we    = b_we;
            sel_addr  = b_addr;
            sel_wdata = b_wdata;
        end
    end

    // Next-state logic. The wait counter is reloaded on entry to RD and
    // WR_PULSE with (length - 1) and the state is left when it reaches 0.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        grant_take = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    grant_take = 1'b1;
                    if (sel_we) begin
                        state_next = ST_WR_SETUP;
                    end else begin
                        state_next = ST_RD;
                        cnt_next   = CNT_W'(RD_CYCLES - 1);
                    end
                end
            end
            ST_RD: begin
                if (cnt == '0) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_WR_SETUP: begin
                state_next = ST_WR_PULSE;
                cnt_next   = CNT_W'(WE_CYCLES - 1);
            end
            ST_WR_PULSE: begin
                if (cnt == '0) begin
                    state_next = ST_WR_HOLD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_WR_HOLD: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                // Always pass through IDLE so a req still high during the
                // ack cycle is not granted a second time.
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register plus registered outputs. Strobes are decoded from
    // state_next so they line up exactly with the state they belong to.
    // Address/data only change at the grant edge (entry to RD/WR_SETUP),
    // which keeps them away from the WE falling edge one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            last_grant  <= PORT_B;
            owner       <= PORT_A;
            ext_RAMA    <= '0;
            ext_RAMDout <= '0;
            ext_RAMCS_b <= 1'b1;
            ext_RAMOE_b <= 1'b1;
            ext_RAMWE_b <= 1'b1;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            a_rdata     <= '0;
            b_rdata     <= '0;
            busy        <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;

            if (grant_take) begin
                owner       <= grant_id;
                last_grant  <= grant_id;
                ext_RAMA    <= sel_addr;
                ext_RAMDout <= sel_wdata;
            end

            ext_RAMCS_b <= !((state_next == ST_RD)       ||
                             (state_next == ST_WR_SETUP) ||
                             (state_next == ST_WR_PULSE) ||
                             (state_next == ST_WR_HOLD));
            ext_RAMOE_b <= (state_next != ST_RD);
            ext_RAMWE_b <= (state_next != ST_WR_PULSE);
            busy        <= (state_next != ST_IDLE);

            // owner is fixed from the grant edge onward, so it is valid here.
            a_ack <= (state_next == ST_DONE) && (owner == PORT_A);
            b_ack <= (state_next == ST_DONE) && (owner == PORT_B);

            // Sample read data at the end of the last OE-low cycle.
            if ((state == ST_RD) && (cnt == '0)) begin
                if (owner == PORT_A) begin
                    a_rdata <= ext_RAMDin;
                end else begin
                    b_rdata <= ext_RAMDin;
                end
            end
        end
    end

endmodule
